// File: rtl/alu_flag_stage.sv
// rtl/alu_flag_stage.sv - ALU flag stage: NZCV register, condition evaluation, 2-entry writeback FIFO
//
// Optional feature macro: ALU_PERF_CNT_EN
//   When defined, adds perf_clr / cond_fail_cnt, a saturating count of accepted ops whose
//   condition failed. When undefined, those ports and the counter do not exist.

module alu_flag_stage #(
    parameter int bits = 32,
    parameter int RDW  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [bits-1:0] in_result,
    input  logic [3:0]      in_flags,
    input  logic            in_setflags,
    input  logic [3:0]      in_cond,
    input  logic [RDW-1:0]  in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bits-1:0] out_result,
    output logic [RDW-1:0]  out_rd,
    output logic            out_wen,
    output logic [3:0]      nzcv
`ifdef ALU_PERF_CNT_EN
    ,
    input  logic            perf_clr,
    output logic [31:0]     cond_fail_cnt
`endif
);

    // Condition codes, ARM encoding
    localparam logic [3:0] condEq = 4'b0000;
    localparam logic [3:0] condNe = 4'b0001;
    localparam logic [3:0] condCs = 4'b0010;
    localparam logic [3:0] condCc = 4'b0011;
    localparam logic [3:0] condMi = 4'b0100;
    localparam logic [3:0] condPl = 4'b0101;
    localparam logic [3:0] condVs = 4'b0110;
    localparam logic [3:0] condVc = 4'b0111;
    localparam logic [3:0] condHi = 4'b1000;
    localparam logic [3:0] condLs = 4'b1001;
    localparam logic [3:0] condGe = 4'b1010;
    localparam logic [3:0] condLt = 4'b1011;
    localparam logic [3:0] condGt = 4'b1100;
    localparam logic [3:0] condLe = 4'b1101;

    // FIFO bookkeeping
    logic [1:0]      count;
    logic            headPtr;
    logic            tailPtr;

    // FIFO storage; data entries are not reset, only the occupancy is
    logic [bits-1:0] memResult [2];
    logic [RDW-1:0]  memRd     [2];
    logic            memWen    [2];

    // Per-cycle handshake and next-state terms
    logic            accept;
    logic            drain;
    logic            condPass;
    logic [1:0]      countNext;
    logic            headNext;
    logic [bits-1:0] headResultNext;
    logic [RDW-1:0]  headRdNext;
    logic            headWenNext;

    // Evaluate a condition code against a flag word {N,Z,C,V}; 1110 and 1111 both mean always
    function automatic logic condEval(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic c;
        logic v;
        logic result;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            condEq:  result = z;
            condNe:  result = !z;
            condCs:  result = c;
            condCc:  result = !c;
            condMi:  result = n;
            condPl:  result = !n;
            condVs:  result = v;
            condVc:  result = !v;
            condHi:  result = c & !z;
            condLs:  result = !c | z;
            condGe:  result = (n == v);
            condLt:  result = (n != v);
            condGt:  result = !z & (n == v);
            condLe:  result = z | (n != v);
            default: result = 1'b1;
        endcase
        return result;
    endfunction

    // in_ready depends only on registered occupancy, so a same-cycle drain cannot raise it
    assign in_ready = (count != 2'd2);

    // Handshakes, condition check against the pre-update flags, and the next FIFO head
    always_comb begin
        accept   = in_valid & in_ready;
        drain    = out_valid & out_ready;
        condPass = condEval(in_cond, nzcv);

        countNext = count;
        case ({accept, drain})
            2'b10:   countNext = count + 2'd1;
            2'b01:   countNext = count - 2'd1;
            default: countNext = count;
        endcase

        headNext = headPtr ^ drain;

        // The incoming op becomes the head when it lands in the slot the head moves to
        if (accept && (tailPtr == headNext)) begin
            headResultNext = in_result;
            headRdNext     = in_rd;
            headWenNext    = condPass;
        end else begin
            headResultNext = memResult[headNext];
            headRdNext     = memRd[headNext];
            headWenNext    = memWen[headNext];
        end
    end

    // Write accepted ops into the tail slot
    always_ff @(posedge clk) begin
        if (accept) begin
            memResult[tailPtr] <= in_result;
            memRd[tailPtr]     <= in_rd;
            memWen[tailPtr]    <= condPass;
        end
    end

    // Occupancy, pointers, registered head outputs and the architectural flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 2'd0;
            headPtr    <= 1'b0;
            tailPtr    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            nzcv       <= 4'b0000;
        end else begin
            count     <= countNext;
            headPtr   <= headNext;
            out_valid <= (countNext != 2'd0);
            if (accept) begin
                tailPtr <= ~tailPtr;
            end
            // When the FIFO goes empty the head outputs keep their last value
            if (countNext != 2'd0) begin
                out_result <= headResultNext;
                out_rd     <= headRdNext;
                out_wen    <= headWenNext;
            end
            // Flags become visible to the next op one cycle later; there is no bypass
            if (accept && condPass && in_setflags) begin
                nzcv <= in_flags;
            end
        end
    end

`ifdef ALU_PERF_CNT_EN
    // Saturating count of accepted ops whose condition failed; clear takes priority
    always_ff @(posedge clk) begin
        if (reset || perf_clr) begin
            cond_fail_cnt <= 32'd0;
        end else if (accept && !condPass && (cond_fail_cnt != 32'hFFFF_FFFF)) begin
            cond_fail_cnt <= cond_fail_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// tb/tb_alu_flag_stage.sv - directed table-driven bench for alu_flag_stage

module tb_alu_flag_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic        in_setflags;
    logic [3:0]  in_cond;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_wen;
    logic [3:0]  nzcv;
`ifdef ALU_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] cond_fail_cnt;
`endif

    int testsRun;
    int failCount;

    typedef struct {
        logic [3:0]  cond;
        logic        setFlags;
        logic [3:0]  flags;
        logic [31:0] result;
        logic [3:0]  rd;
        logic        expWen;
        logic [3:0]  expNzcv;
    } opVector;

    opVector vecs [18];

    alu_flag_stage #(.bits(32), .RDW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_setflags  (in_setflags),
        .in_cond      (in_cond),
        .in_rd        (in_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wen      (out_wen),
        .nzcv         (nzcv)
`ifdef ALU_PERF_CNT_EN
        ,
        .perf_clr     (perf_clr),
        .cond_fail_cnt(cond_fail_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveOp(input logic [3:0] cond, input logic s, input logic [3:0] flags,
                           input logic [31:0] result, input logic [3:0] rd);
        in_valid    = 1'b1;
        in_cond     = cond;
        in_setflags = s;
        in_flags    = flags;
        in_result   = result;
        in_rd       = rd;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;

        // cond, S, flags, result, rd, expected wen, expected nzcv afterwards
        vecs[0]  = '{4'b1110, 1'b1, 4'b0100, 32'h0000_0000, 4'd1,  1'b1, 4'b0100};
        vecs[1]  = '{4'b0000, 1'b1, 4'b1000, 32'h0000_0011, 4'd2,  1'b1, 4'b1000};
        vecs[2]  = '{4'b0000, 1'b1, 4'b0100, 32'h0000_0022, 4'd3,  1'b0, 4'b1000};
        vecs[3]  = '{4'b1110, 1'b1, 4'b1001, 32'hFFFF_FFFF, 4'd15, 1'b1, 4'b1001};
        vecs[4]  = '{4'b1010, 1'b0, 4'b0000, 32'h8000_0001, 4'd4,  1'b1, 4'b1001};
        vecs[5]  = '{4'b1011, 1'b0, 4'b0000, 32'h1234_5678, 4'd5,  1'b0, 4'b1001};
        vecs[6]  = '{4'b1100, 1'b0, 4'b0000, 32'hCAFE_F00D, 4'd6,  1'b1, 4'b1001};
        vecs[7]  = '{4'b1101, 1'b0, 4'b0000, 32'h0BAD_BEEF, 4'd7,  1'b0, 4'b1001};
        vecs[8]  = '{4'b1000, 1'b0, 4'b0000, 32'h5555_AAAA, 4'd8,  1'b0, 4'b1001};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0000, 32'hAAAA_5555, 4'd9,  1'b1, 4'b1001};
        vecs[10] = '{4'b0100, 1'b1, 4'b0010, 32'h0000_00A0, 4'd10, 1'b1, 4'b0010};
        vecs[11] = '{4'b0010, 1'b1, 4'b0001, 32'h0000_00A1, 4'd11, 1'b1, 4'b0001};
        vecs[12] = '{4'b0111, 1'b1, 4'b1111, 32'h0000_00A2, 4'd12, 1'b0, 4'b0001};
        vecs[13] = '{4'b0110, 1'b0, 4'b1111, 32'h0000_00A3, 4'd13, 1'b1, 4'b0001};
        vecs[14] = '{4'b1001, 1'b0, 4'b0000, 32'h0000_00A4, 4'd14, 1'b1, 4'b0001};
        vecs[15] = '{4'b0001, 1'b1, 4'b0110, 32'h0000_00A5, 4'd0,  1'b1, 4'b0110};
        vecs[16] = '{4'b0011, 1'b0, 4'b0000, 32'h0000_00A6, 4'd1,  1'b0, 4'b0110};
        vecs[17] = '{4'b0101, 1'b0, 4'b0000, 32'h0000_00A7, 4'd2,  1'b1, 4'b0110};

        // Reset held two cycles while an op is offered
        reset     = 1'b1;
        out_ready = 1'b1;
`ifdef ALU_PERF_CNT_EN
        perf_clr  = 1'b0;
`endif
        driveOp(4'b1110, 1'b1, 4'b1111, 32'h0000_AAAA, 4'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset nzcv", 32'(nzcv), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_result", out_result, 32'd0);
        check("reset out_rd", 32'(out_rd), 32'd0);
        check("reset out_wen", 32'(out_wen), 32'd0);

        // One op at a time through an empty FIFO
        for (int i = 0; i < 18; i++) begin
            driveOp(vecs[i].cond, vecs[i].setFlags, vecs[i].flags, vecs[i].result, vecs[i].rd);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d out_result", i), out_result, vecs[i].result);
            check($sformatf("vec%0d out_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d out_wen", i), 32'(out_wen), 32'(vecs[i].expWen));
            check($sformatf("vec%0d nzcv", i), 32'(nzcv), 32'(vecs[i].expNzcv));
            @(negedge clk);
            check($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
        end

        // Back-to-back: second op must see the flags written by the first (Z cleared)
        driveOp(4'b1110, 1'b1, 4'b0000, 32'h0000_A0A0, 4'd7);
        @(negedge clk);
        driveOp(4'b0000, 1'b0, 4'b0000, 32'h0000_B0B0, 4'd8);
        check("b2b A result", out_result, 32'h0000_A0A0);
        check("b2b A wen", 32'(out_wen), 32'd1);
        check("b2b nzcv", 32'(nzcv), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b B valid", 32'(out_valid), 32'd1);
        check("b2b B result", out_result, 32'h0000_B0B0);
        check("b2b B rd", 32'(out_rd), 32'd8);
        check("b2b B wen", 32'(out_wen), 32'd0);
        @(negedge clk);
        check("b2b empty", 32'(out_valid), 32'd0);

        // Fill to two with the sink stalled, third op held, then drain in order
        out_ready = 1'b0;
        check("full A in_ready", 32'(in_ready), 32'd1);
        driveOp(4'b1110, 1'b0, 4'b0000, 32'h1111_1111, 4'd1);
        @(negedge clk);
        check("full B in_ready", 32'(in_ready), 32'd1);
        check("full head A", out_result, 32'h1111_1111);
        driveOp(4'b1110, 1'b0, 4'b0000, 32'h2222_2222, 4'd2);
        @(negedge clk);
        check("full in_ready low", 32'(in_ready), 32'd0);
        driveOp(4'b1110, 1'b0, 4'b0000, 32'h3333_3333, 4'd3);
        @(negedge clk);
        check("full held in_ready", 32'(in_ready), 32'd0);
        check("full stable head", out_result, 32'h1111_1111);
        check("full stable rd", 32'(out_rd), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain head B", out_result, 32'h2222_2222);
        check("drain in_ready back", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain head C valid", 32'(out_valid), 32'd1);
        check("drain head C", out_result, 32'h3333_3333);
        check("drain head C rd", 32'(out_rd), 32'd3);
        @(negedge clk);
        check("drain empty", 32'(out_valid), 32'd0);
        check("drain hold result", out_result, 32'h3333_3333);
        check("drain hold rd", 32'(out_rd), 32'd3);

        // Reset while full discards both entries and the flags
        out_ready = 1'b0;
        driveOp(4'b1110, 1'b1, 4'b1010, 32'h4444_4444, 4'd4);
        @(negedge clk);
        driveOp(4'b1110, 1'b1, 4'b1010, 32'h5555_5555, 4'd5);
        @(negedge clk);
        check("prereset full", 32'(in_ready), 32'd0);
        check("prereset nzcv", 32'(nzcv), 32'b1010);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("fullreset out_valid", 32'(out_valid), 32'd0);
        check("fullreset nzcv", 32'(nzcv), 32'd0);
        check("fullreset in_ready", 32'(in_ready), 32'd1);

`ifdef ALU_PERF_CNT_EN
        // Three failing EQ ops (Z=0), then a pass, then clear racing a fail
        check("perf after reset", cond_fail_cnt, 32'd0);
        driveOp(4'b0000, 1'b0, 4'b0000, 32'h0000_0C01, 4'd1);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("perf three fails", cond_fail_cnt, 32'd3);
        driveOp(4'b1110, 1'b0, 4'b0000, 32'h0000_0C02, 4'd2);
        @(negedge clk);
        in_valid = 1'b0;
        check("perf pass no inc", cond_fail_cnt, 32'd3);
        @(negedge clk);
        perf_clr = 1'b1;
        driveOp(4'b0000, 1'b0, 4'b0000, 32'h0000_0C03, 4'd3);
        @(negedge clk);
        perf_clr = 1'b0;
        in_valid = 1'b0;
        check("perf clear wins", cond_fail_cnt, 32'd0);
        @(negedge clk);
        driveOp(4'b0000, 1'b0, 4'b0000, 32'h0000_0C04, 4'd4);
        @(negedge clk);
        in_valid = 1'b0;
        check("perf after clear", cond_fail_cnt, 32'd1);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
